// File: rtl/brick_draw_sequencer_if.sv
// brick_draw_sequencer_if
// Bus between the brick draw sequencer (master) and the brick drawer
// controller and datapath (slave).
//   draw_done     drawer -> sequencer  drawer has finished the current brick
//   draw_enable   sequencer -> drawer  drawer enable_state pin
//   draw_reset_n  sequencer -> drawer  drawer reset_state pin, active low
//   brick_x       sequencer -> drawer  origin x of the current brick
//   brick_y       sequencer -> drawer  origin y of the current brick
//   brick_colour  sequencer -> drawer  RGB colour of the current brick
//   brick_index   sequencer -> drawer  index of the current brick
interface brick_draw_sequencer_if;
    logic       draw_done;
    logic       draw_enable;
    logic       draw_reset_n;
    logic [7:0] brick_x;
    logic [6:0] brick_y;
    logic [2:0] brick_colour;
    logic [5:0] brick_index;

    modport master (
        input  draw_done,
        output draw_enable, draw_reset_n, brick_x, brick_y, brick_colour, brick_index
    );

    modport slave (
        output draw_done,
        input  draw_enable, draw_reset_n, brick_x, brick_y, brick_colour, brick_index
    );
endinterface

// File: rtl/brick_draw_sequencer.sv
// brick_draw_sequencer
// Walks the brick grid once per start pulse. For every brick it presents the
// origin and colour on draw_bus, runs one drawer pass (enable held until the
// drawer reports done) and moves on. Dead bricks are skipped unless
// BRICK_SEQ_ERASE_EN is defined, in which case they are drawn in black.
// Ports:
//   clock        system clock, rising edge
//   reset_state  asynchronous active-low reset
//   start        begin one grid pass (only honoured in IDLE)
//   brick_alive  bit i = brick i alive, i = row*NUM_COLS + col
//   busy         high in every state except IDLE
//   frame_done   one-cycle pulse at the end of a pass
//   draw_bus     master side of the drawer bus
// Optional feature macro: BRICK_SEQ_ERASE_EN
module brick_draw_sequencer #(
    parameter int NUM_COLS = 8,
    parameter int NUM_ROWS = 4,
    parameter int BRICK_W  = 16,
    parameter int BRICK_H  = 4,
    parameter int X0       = 8,
    parameter int Y0       = 8
) (
    input  logic                         clock,
    input  logic                         reset_state,
    input  logic                         start,
    input  logic [NUM_COLS*NUM_ROWS-1:0] brick_alive,
    output logic                         busy,
    output logic                         frame_done,
    brick_draw_sequencer_if.master       draw_bus
);
    localparam int         NUM_BRICKS = NUM_COLS * NUM_ROWS;
    localparam logic [5:0] LAST_INDEX = 6'(NUM_BRICKS - 1);
    localparam logic [5:0] LAST_COL   = 6'(NUM_COLS - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_DRAW, S_NEXT, S_FINISH} state_t;

    state_t     state_reg, state_next;
    logic [5:0] col_reg, col_next;
    logic [5:0] row_reg, row_next;
    logic [5:0] index_reg, index_next;
    logic [7:0] x_reg, x_next;
    logic [6:0] y_reg, y_next;
    logic [2:0] colour_reg, colour_next;
    logic       draw_reset_n_reg;
    logic       draw_enable;
    logic       load_brick;

    // Zero-padded to 64 bits so a 6-bit index is always in range.
    logic [63:0] alive_ext;
    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_alive
            if (gi < NUM_BRICKS) begin : g_used
                assign alive_ext[gi] = brick_alive[gi];
            end else begin : g_pad
                assign alive_ext[gi] = 1'b0;
            end
        end
    endgenerate

    function automatic logic [2:0] row_colour(input logic [1:0] r);
        case (r)
            2'd0:    row_colour = 3'b100;
            2'd1:    row_colour = 3'b110;
            2'd2:    row_colour = 3'b010;
            default: row_colour = 3'b001;
        endcase
    endfunction

    always_ff @(posedge clock or negedge reset_state) begin
        if (!reset_state) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        draw_enable = 1'b0;
        busy        = 1'b1;
        frame_done  = 1'b0;
        load_brick  = 1'b0;
        col_next    = col_reg;
        row_next    = row_reg;
        index_next  = index_reg;
        x_next      = x_reg;
        y_next      = y_reg;
        colour_next = colour_reg;
        case (state_reg)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = S_SETUP;
                    load_brick = 1'b1;
                    col_next   = 6'd0;
                    row_next   = 6'd0;
                    index_next = 6'd0;
                    x_next     = 8'(X0);
                    y_next     = 7'(Y0);
                end
            end
            S_SETUP: begin
`ifdef BRICK_SEQ_ERASE_EN
                state_next = S_DRAW;
`else
                state_next = alive_ext[index_reg] ? S_DRAW : S_NEXT;
`endif
            end
            S_DRAW: begin
                // Enable stays high through the edge that samples done so the
                // drawer steps DONE -> RESET and parks there.
                draw_enable = 1'b1;
                if (draw_bus.draw_done) begin
                    state_next = S_NEXT;
                end
            end
            S_NEXT: begin
                if (index_reg == LAST_INDEX) begin
                    state_next = S_FINISH;
                end else begin
                    state_next = S_SETUP;
                    load_brick = 1'b1;
                    index_next = index_reg + 6'd1;
                    if (col_reg == LAST_COL) begin
                        col_next = 6'd0;
                        row_next = row_reg + 6'd1;
                        x_next   = 8'(X0);
                        y_next   = y_reg + 7'(BRICK_H);
                    end else begin
                        col_next = col_reg + 6'd1;
                        x_next   = x_reg + 8'(BRICK_W);
                    end
                end
            end
            S_FINISH: begin
                frame_done = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        // Colour is fixed when the brick is loaded so it is already stable
        // on SETUP entry.
        if (load_brick) begin
            colour_next = row_colour(row_next[1:0]);
`ifdef BRICK_SEQ_ERASE_EN
            if (!alive_ext[index_next]) begin
                colour_next = 3'b000;
            end
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_state) begin
        if (!reset_state) begin
            col_reg          <= 6'd0;
            row_reg          <= 6'd0;
            index_reg        <= 6'd0;
            x_reg            <= 8'd0;
            y_reg            <= 7'd0;
            colour_reg       <= 3'd0;
            draw_reset_n_reg <= 1'b0;
        end else begin
            col_reg          <= col_next;
            row_reg          <= row_next;
            index_reg        <= index_next;
            x_reg            <= x_next;
            y_reg            <= y_next;
            colour_reg       <= colour_next;
            // Drawer is held in reset whenever the sequencer sits in IDLE.
            draw_reset_n_reg <= (state_next != S_IDLE);
        end
    end

    assign draw_bus.draw_enable  = draw_enable;
    assign draw_bus.draw_reset_n = draw_reset_n_reg;
    assign draw_bus.brick_x      = x_reg;
    assign draw_bus.brick_y      = y_reg;
    assign draw_bus.brick_colour = colour_reg;
    assign draw_bus.brick_index  = index_reg;
endmodule

// File: tb/tb_brick_draw_sequencer.sv
module tb_brick_draw_sequencer;
    logic        clock = 1'b0;
    logic        reset_state = 1'b0;
    logic        start = 1'b0;
    logic [31:0] brick_alive = 32'd0;
    logic        busy;
    logic        frame_done;

    brick_draw_sequencer_if bus();

    brick_draw_sequencer dut (
        .clock       (clock),
        .reset_state (reset_state),
        .start       (start),
        .brick_alive (brick_alive),
        .busy        (busy),
        .frame_done  (frame_done),
        .draw_bus    (bus)
    );

    always #5 clock = ~clock;

    // Standard drawer: RESET, LOAD, 64 plot cycles, DONE (67 enabled cycles).
    logic [6:0] drw_cnt;
    always @(posedge clock or negedge bus.draw_reset_n) begin
        if (!bus.draw_reset_n) drw_cnt <= 7'd0;
        else if (bus.draw_enable) drw_cnt <= (drw_cnt == 7'd66) ? 7'd0 : drw_cnt + 7'd1;
    end
    assign bus.draw_done = bus.draw_enable && (drw_cnt == 7'd66);

    typedef struct { int idx; int x; int y; int c; } draw_t;
    draw_t exp_draw[$];
    int    exp_frame[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    start_cyc = 0;
    int    seen_x[64];
    int    seen_y[64];
    int    seen_c[64];
    logic [2:0] ctab [4] = '{3'b100, 3'b110, 3'b010, 3'b001};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a draw starts or a frame ends.
    initial begin
        logic busy_q = 1'b0;
        logic en_q = 1'b0;
        draw_t e;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset_state) begin
                if (busy && !busy_q) start_cyc = cyc;
                if (bus.draw_enable && !en_q) begin
                    seen_x[bus.brick_index] = int'(bus.brick_x);
                    seen_y[bus.brick_index] = int'(bus.brick_y);
                    seen_c[bus.brick_index] = int'(bus.brick_colour);
                    if (exp_draw.size() == 0) begin
                        check("unexpected_draw_index", int'(bus.brick_index), -1);
                    end else begin
                        e = exp_draw.pop_front();
                        check("draw_index", int'(bus.brick_index), e.idx);
                        check("draw_x", int'(bus.brick_x), e.x);
                        check("draw_y", int'(bus.brick_y), e.y);
                        check("draw_colour", int'(bus.brick_colour), e.c);
                    end
                end
                if (frame_done) begin
                    if (exp_frame.size() == 0) check("unexpected_frame_cycles", cyc - start_cyc, -1);
                    else check("frame_cycles", cyc - start_cyc, exp_frame.pop_front());
                end
            end
            busy_q = busy;
            en_q = bus.draw_enable;
        end
    end

    task automatic push_pass(input logic [31:0] alive, input logic erase);
        int n_draw = 0;
        for (int i = 0; i < 32; i++) begin
            if (alive[i] || erase) begin
                exp_draw.push_back('{i, 8 + 16 * (i % 8), 8 + 4 * (i / 8),
                                     alive[i] ? int'(ctab[i / 8]) : 0});
                n_draw++;
            end
        end
        exp_frame.push_back(n_draw * 69 + (32 - n_draw) * 2);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_frame(input int budget);
        int n = 0;
        while (!frame_done && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (!frame_done) check("frame_timeout", 0, 1);
        repeat (4) @(negedge clock);
    endtask

    task automatic check_drained(input string name);
        check({name, "_draws_left"}, exp_draw.size(), 0);
        check({name, "_frames_left"}, exp_frame.size(), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_draw_enable"}, int'(bus.draw_enable), 0);
        check({name, "_draw_reset_n"}, int'(bus.draw_reset_n), 0);
        check({name, "_brick_x"}, int'(bus.brick_x), 0);
        check({name, "_brick_y"}, int'(bus.brick_y), 0);
        check({name, "_brick_colour"}, int'(bus.brick_colour), 0);
        check({name, "_brick_index"}, int'(bus.brick_index), 0);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_frame_done"}, int'(frame_done), 0);
    endtask

    logic erase_on;

    initial begin
`ifdef BRICK_SEQ_ERASE_EN
        erase_on = 1'b1;
`else
        erase_on = 1'b0;
`endif
        #7;
        check_reset_outputs("reset");
        repeat (2) @(negedge clock);
        reset_state = 1'b1;
        repeat (2) @(negedge clock);
        check("idle_draw_reset_n", int'(bus.draw_reset_n), 0);

        // All bricks alive.
        for (int i = 0; i < 64; i++) seen_x[i] = -1;
        brick_alive = 32'hFFFF_FFFF;
        push_pass(brick_alive, erase_on);
        pulse_start();
        check("setup_draw_reset_n", int'(bus.draw_reset_n), 1);
        wait_frame(3000);
        check("busy_after_frame", int'(busy), 0);
        check("brick9_x", seen_x[9], 24);
        check("brick9_y", seen_y[9], 12);
        check("brick9_colour", seen_c[9], 3'b110);
        check_drained("all_alive");
        $display("pass all_alive done");

        // No bricks alive.
        brick_alive = 32'd0;
        push_pass(brick_alive, erase_on);
        pulse_start();
        wait_frame(3000);
        check_drained("all_dead");
        $display("pass all_dead done");

        // Only brick 31 alive.
        for (int i = 0; i < 64; i++) seen_x[i] = -1;
        brick_alive = 32'h8000_0000;
        push_pass(brick_alive, erase_on);
        pulse_start();
        wait_frame(3000);
        check("brick31_x", seen_x[31], 120);
        check("brick31_y", seen_y[31], 20);
        check("brick31_colour", seen_c[31], 3'b001);
        check_drained("only31");
        $display("pass only31 done");

        // Reset during the draw of brick 5.
        brick_alive = 32'hFFFF_FFFF;
        for (int i = 0; i < 6; i++)
            exp_draw.push_back('{i, 8 + 16 * i, 8, int'(ctab[0])});
        pulse_start();
        begin
            int n = 0;
            while (!(bus.draw_enable && bus.brick_index == 6'd5) && n < 1000) begin
                @(negedge clock);
                n++;
            end
            check("reach_brick5", int'(bus.draw_enable && bus.brick_index == 6'd5), 1);
        end
        repeat (10) @(negedge clock);
        #2 reset_state = 1'b0;
        #1 check_reset_outputs("midreset");
        repeat (2) @(negedge clock);
        reset_state = 1'b1;
        repeat (5) @(negedge clock);
        check_drained("midreset");
        $display("pass midreset done");

        // Restart after reset, with start re-pulsed while busy.
        push_pass(brick_alive, erase_on);
        pulse_start();
        check("restart_index", int'(bus.brick_index), 0);
        repeat (10) @(negedge clock);
        pulse_start();
        repeat (500) @(negedge clock);
        pulse_start();
        repeat (1000) @(negedge clock);
        pulse_start();
        wait_frame(3000);
        repeat (100) @(negedge clock);
        check("repulse_busy_idle", int'(busy), 0);
        check_drained("repulse");
        $display("pass repulse done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
